// File: rtl/fp_scoreboard_pkg.sv
// Shared definitions for the FPU scoreboard: slot record, parameter defaults
// and FPU function encodings.
package fp_scoreboard_pkg;

  localparam int FP_STAGES_DEF = 3;
  localparam int DS_LAT_DEF    = 4;
  localparam int RN_W_DEF      = 5;
  localparam int DS_CNT_W      = 4;

  typedef struct packed {
    logic                v;
    logic [RN_W_DEF-1:0] rn;
  } fp_slot_t;

  typedef enum logic [2:0] {
    FP_FADD  = 3'd0,
    FP_FSUB  = 3'd1,
    FP_FMUL  = 3'd2,
    FP_FDIV  = 3'd3,
    FP_FSQRT = 3'd4
  } fp_func_e;

endpackage

// File: rtl/fp_stage_slot.sv
// One FPU pipeline tracking slot {v, rn}; can hold its contents or take a bubble
// instead of the upstream slot.
module fp_stage_slot
  import fp_scoreboard_pkg::*;
#(
  parameter int RN_W = RN_W_DEF
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            hold,
  input  logic            bubble,
  input  logic            d_v,
  input  logic [RN_W-1:0] d_rn,
  output logic            q_v,
  output logic [RN_W-1:0] q_rn
);

  logic            v_r;
  logic [RN_W-1:0] rn_r;

  // Slot register: hold wins over bubble, bubble only invalidates
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v_r  <= 1'b0;
      rn_r <= '0;
    end else if (hold) begin
      v_r  <= v_r;
      rn_r <= rn_r;
    end else if (bubble) begin
      v_r  <= 1'b0;
      rn_r <= d_rn;
    end else begin
      v_r  <= d_v;
      rn_r <= d_rn;
    end
  end

  assign q_v  = v_r;
  assign q_rn = rn_r;

endmodule

// File: rtl/fp_scoreboard.sv
// FPU issue scoreboard: tracks destination registers through E1..EN, detects
// RAW and load hazards, holds E1 during div/sqrt and drives EN forwarding/writeback.
module fp_scoreboard
  import fp_scoreboard_pkg::*;
#(
  parameter int FP_STAGES = FP_STAGES_DEF,
  parameter int RN_W      = RN_W_DEF,
  parameter int DS_LAT    = DS_LAT_DEF
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            id_fwr,
  input  logic            id_ds,
  input  logic            id_use_fs,
  input  logic            id_use_ft,
  input  logic [RN_W-1:0] id_fs,
  input  logic [RN_W-1:0] id_ft,
  input  logic [RN_W-1:0] id_fd,
  input  logic            ld_ewfpr,
  input  logic [RN_W-1:0] ld_ern,
  input  logic            ext_stall,
  input  logic            cancel,
  output logic            stall,
  output logic            stall_ds,
  output logic            fwd_a,
  output logic            fwd_b,
  output logic            issue,
  output logic            wb_we,
  output logic [RN_W-1:0] wb_rn
);

  logic [FP_STAGES-1:0] slot_v_s;
  logic [RN_W-1:0]      slot_rn_s [FP_STAGES];
  logic [DS_CNT_W-1:0]  ds_cnt_r;
  logic                 stall_ds_s;
  logic                 stall_dep_s;
  logic                 stall_ld_s;
  logic                 stall_s;
  logic                 issue_s;

  function automatic logic src_hit(input logic [RN_W-1:0] rn,
                                   input logic use_fs, input logic [RN_W-1:0] fs,
                                   input logic use_ft, input logic [RN_W-1:0] ft);
    return (use_fs && (rn == fs)) || (use_ft && (rn == ft));
  endfunction

  genvar k;
  generate
    for (k = 0; k < FP_STAGES; k++) begin : g_slot
      if (k == 0) begin : g_e1
        // E1 holds the div/sqrt for its whole latency
        fp_stage_slot #(.RN_W(RN_W)) u_slot (
          .clk(clk), .clrn(clrn), .hold(stall_ds_s), .bubble(1'b0),
          .d_v(issue_s), .d_rn(id_fd), .q_v(slot_v_s[k]), .q_rn(slot_rn_s[k]));
      end else begin : g_en
        fp_stage_slot #(.RN_W(RN_W)) u_slot (
          .clk(clk), .clrn(clrn), .hold(1'b0), .bubble((k == 1) && stall_ds_s),
          .d_v(slot_v_s[k-1]), .d_rn(slot_rn_s[k-1]),
          .q_v(slot_v_s[k]), .q_rn(slot_rn_s[k]));
      end
    end
  endgenerate

  // RAW hazard against every in-flight op that has not yet reached EN
  always_comb begin
    stall_dep_s = 1'b0;
    for (int i = 0; i < FP_STAGES - 1; i++) begin
      if (slot_v_s[i] && src_hit(slot_rn_s[i], id_use_fs, id_fs, id_use_ft, id_ft)) begin
        stall_dep_s = 1'b1;
      end else begin
        stall_dep_s = stall_dep_s;
      end
    end
  end

  assign stall_ld_s = ld_ewfpr && src_hit(ld_ern, id_use_fs, id_fs, id_use_ft, id_ft);
  assign stall_ds_s = (ds_cnt_r != {DS_CNT_W{1'b0}});
  assign stall_s    = stall_dep_s || stall_ld_s || stall_ds_s || ext_stall;
  assign issue_s    = id_fwr && !stall_s && !cancel;

  // Div/sqrt occupancy counter; issue is impossible while it is nonzero
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ds_cnt_r <= {DS_CNT_W{1'b0}};
    end else if (stall_ds_s) begin
      ds_cnt_r <= ds_cnt_r - {{(DS_CNT_W-1){1'b0}}, 1'b1};
    end else if (issue_s && id_ds) begin
      ds_cnt_r <= DS_CNT_W'(DS_LAT);
    end else begin
      ds_cnt_r <= ds_cnt_r;
    end
  end

  assign stall    = stall_s;
  assign stall_ds = stall_ds_s;
  assign issue    = issue_s;
  assign fwd_a    = id_use_fs && slot_v_s[FP_STAGES-1] && (slot_rn_s[FP_STAGES-1] == id_fs);
  assign fwd_b    = id_use_ft && slot_v_s[FP_STAGES-1] && (slot_rn_s[FP_STAGES-1] == id_ft);
  assign wb_we    = slot_v_s[FP_STAGES-1];
  assign wb_rn    = slot_rn_s[FP_STAGES-1];

endmodule

// File: tb/tb_fp_scoreboard.sv
// Self-checking bench for fp_scoreboard: a directed div/sqrt timeline, then
// randomized traffic checked against an op-list reference model.
module tb_fp_scoreboard;

  localparam int N   = 3;
  localparam int RW  = 5;
  localparam int DSL = 4;

  logic          clk = 1'b0;
  logic          clrn;
  logic          id_fwr, id_ds, id_use_fs, id_use_ft;
  logic [RW-1:0] id_fs, id_ft, id_fd, ld_ern, wb_rn;
  logic          ld_ewfpr, ext_stall, cancel;
  logic          stall, stall_ds, fwd_a, fwd_b, issue, wb_we;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { int rn; int pos; } op_t;
  op_t ops[$];
  int  ds_left;
  bit  e_issue, e_div;

  fp_scoreboard #(.FP_STAGES(N), .RN_W(RW), .DS_LAT(DSL)) dut (
    .clk(clk), .clrn(clrn), .id_fwr(id_fwr), .id_ds(id_ds),
    .id_use_fs(id_use_fs), .id_use_ft(id_use_ft), .id_fs(id_fs), .id_ft(id_ft),
    .id_fd(id_fd), .ld_ewfpr(ld_ewfpr), .ld_ern(ld_ern), .ext_stall(ext_stall),
    .cancel(cancel), .stall(stall), .stall_ds(stall_ds), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .issue(issue), .wb_we(wb_we), .wb_rn(wb_rn));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_op(input bit fwr, input bit ds, input int fd, input int fs, input int ft);
    id_fwr = fwr; id_ds = ds; id_fd = RW'(fd); id_fs = RW'(fs); id_ft = RW'(ft);
    id_use_fs = 1'b1; id_use_ft = 1'b1;
  endtask

  function automatic bit reads(input int rn);
    return (id_use_fs && rn == int'(id_fs)) || (id_use_ft && rn == int'(id_ft));
  endfunction

  // Compare all outputs against the model for the current inputs
  task automatic model_check();
    bit dep = 0, fa = 0, fb = 0, wb = 0, ld, ds, st;
    int wrn = 0;
    foreach (ops[i]) begin
      if (ops[i].pos < N && reads(ops[i].rn)) dep = 1;
      if (ops[i].pos == N) begin
        wb = 1; wrn = ops[i].rn;
        fa = id_use_fs && ops[i].rn == int'(id_fs);
        fb = id_use_ft && ops[i].rn == int'(id_ft);
      end
    end
    ld = ld_ewfpr && reads(int'(ld_ern));
    ds = ds_left > 0;
    st = dep || ld || ds || ext_stall;
    e_issue = id_fwr && !st && !cancel;
    e_div   = id_ds;
    chk("stall", stall, st);
    chk("stall_ds", stall_ds, ds);
    chk("issue", issue, e_issue);
    chk("fwd_a", fwd_a, fa);
    chk("fwd_b", fwd_b, fb);
    chk("wb_we", wb_we, wb);
    if (wb) chk("wb_rn", wb_rn, wrn);
  endtask

  // Advance the model by one clock edge
  task automatic model_step();
    op_t nq[$];
    foreach (ops[i]) begin
      op_t o = ops[i];
      if (!(o.pos == 1 && ds_left > 0)) o.pos++;
      if (o.pos <= N) nq.push_back(o);
    end
    if (ds_left > 0) ds_left--;
    if (e_issue) begin
      nq.push_back('{rn: int'(id_fd), pos: 1});
      if (e_div) ds_left = DSL;
    end
    ops = nq;
  endtask

  initial begin
    clrn = 1'b0; drive_op(0, 0, 0, 0, 0);
    ld_ewfpr = 1'b0; ld_ern = '0; ext_stall = 1'b0; cancel = 1'b0;
    ds_left = 0;
    #1;
    chk("rst_stall_ds", stall_ds, 0);
    chk("rst_wb_we", wb_we, 0);
    @(negedge clk); @(negedge clk);
    clrn = 1'b1;

    // fdiv f4 then a stalled independent fadd f5
    drive_op(1, 1, 4, 1, 2);
    #1 chk("div_issue_t0", issue, 1);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (t <= 5) drive_op(1, 0, 5, 1, 2); else id_fwr = 1'b0;
      #1;
      chk("div_stall_ds", stall_ds, (t <= 4));
      chk("div_issue", issue, (t == 5));
      chk("div_wb_we", wb_we, (t == 7 || t == 8));
      if (t == 7) chk("div_wb_rn4", wb_rn, 4);
      if (t == 8) chk("div_wb_rn5", wb_rn, 5);
    end

    // async reset empties the pipe mid-flight
    @(negedge clk);
    drive_op(1, 1, 9, 1, 2);
    @(negedge clk);
    id_fwr = 1'b0;
    #1 chk("div_busy", stall_ds, 1);
    clrn = 1'b0;
    #1;
    chk("rst_mid_ds", stall_ds, 0);
    chk("rst_mid_wb", wb_we, 0);
    @(negedge clk);
    clrn = 1'b1;
    ops.delete(); ds_left = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      id_fwr    = ($urandom_range(0, 9) < 7);
      id_ds     = id_fwr && ($urandom_range(0, 19) < 3);
      id_use_fs = ($urandom_range(0, 9) < 8);
      id_use_ft = ($urandom_range(0, 9) < 6);
      id_fs     = RW'($urandom_range(0, 7));
      id_ft     = RW'($urandom_range(0, 7));
      id_fd     = RW'($urandom_range(0, 7));
      ld_ewfpr  = ($urandom_range(0, 19) < 3);
      ld_ern    = RW'($urandom_range(0, 7));
      ext_stall = ($urandom_range(0, 9) == 0);
      cancel    = ($urandom_range(0, 9) == 0);
      clrn      = ($urandom_range(0, 49) != 0);
      if (!clrn) begin
        ops.delete(); ds_left = 0;
      end
      #1 model_check();
      @(posedge clk);
      if (clrn) model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
